elevator_controller: RTL and testbench

Floor-sequencing state machine for the three-floor elevator. It consumes the latched call-request lamps from the button stage and decides which way the car moves, when it stops, and how long the door stays open. Its `floor` output feeds back into the button stage, which clears the lamp of the floor the car is at. Its `move_handler` output reports when the car is in motion.

---
 rtl/elevator_pkg.sv | 33 +++
 rtl/elevator_controller_travel_timer.sv | 35 +++
 rtl/elevator_controller.sv | 158 +++++++++++++++
 tb/tb_elevator_controller.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/elevator_pkg.sv
// Shared definitions for the three-floor elevator: floor labels, controller
// states and default timing.
package elevator_pkg;

    localparam logic [1:0] LABEL_F1 = 2'b00;
    localparam logic [1:0] LABEL_F2 = 2'b01;
    localparam logic [1:0] LABEL_F3 = 2'b10;

    localparam int DEFAULT_TRAVEL_CYCLES = 50;
    localparam int DEFAULT_DOOR_CYCLES   = 100;

    typedef enum logic [1:0] {
        IDLE,
        MOVE_UP,
        MOVE_DOWN,
        DOOR
    } state_e;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Floor index 0..2 selects the call lamp; index 3 never occurs and reads as no request.
    function automatic logic req_at(input logic [2:0] r, input logic [1:0] idx);
        case (idx)
            2'd0:    return r[0];
            2'd1:    return r[1];
            2'd2:    return r[2];
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/elevator_controller_travel_timer.sv
// Loadable down-counter shared by travel and door timing; holds at zero,
// where it reports expired.
module travel_timer #(
    parameter int WIDTH = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] value,
    output logic             expired
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = value;
        end else if (count_q != '0) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = (count_q == '0);

endmodule

// File: rtl/elevator_controller.sv
// Floor-sequencing FSM for the three-floor car: picks travel direction, stop
// floors and door hold time from the latched call lamps.
module elevator_controller
    import elevator_pkg::*;
#(
    parameter logic [1:0] labelF1       = LABEL_F1,
    parameter logic [1:0] labelF2       = LABEL_F2,
    parameter logic [1:0] labelF3       = LABEL_F3,
    parameter int         TRAVEL_CYCLES = DEFAULT_TRAVEL_CYCLES,
    parameter int         DOOR_CYCLES   = DEFAULT_DOOR_CYCLES
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] req,
    output logic [1:0] floor,
    output logic       move_handler,
    output logic       dir_up,
    output logic       door_open
);

    localparam int CNT_W = $clog2(max_int(TRAVEL_CYCLES, DOOR_CYCLES));
    localparam logic [CNT_W-1:0] TRAVEL_LOAD = CNT_W'(TRAVEL_CYCLES - 1);
    localparam logic [CNT_W-1:0] DOOR_LOAD   = CNT_W'(DOOR_CYCLES - 1);

    state_e     state_q, state_d;
    logic [1:0] floor_idx_q, floor_idx_d;
    logic       dir_up_q, dir_up_d;
    logic       move_q, move_d;
    logic       door_q, door_d;

    logic             timer_load;
    logic [CNT_W-1:0] timer_value;
    logic             timer_expired;

    logic       req_here;
    logic       req_above;
    logic       req_below;
    logic [1:0] next_idx;
    logic       req_next;
    logic       req_beyond;

    travel_timer #(
        .WIDTH(CNT_W)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .load   (timer_load),
        .value  (timer_value),
        .expired(timer_expired)
    );

    // Request geometry relative to the current floor and to the floor the car is heading for.
    always_comb begin
        req_here   = req_at(req, floor_idx_q);
        req_above  = 1'b0;
        req_below  = 1'b0;
        next_idx   = floor_idx_q;
        req_beyond = 1'b0;
        case (floor_idx_q)
            2'd0:    req_above = req[1] | req[2];
            2'd1: begin
                req_above = req[2];
                req_below = req[0];
            end
            default: req_below = req[0] | req[1];
        endcase
        if (state_q == MOVE_UP) begin
            next_idx   = (floor_idx_q >= 2'd2) ? 2'd2 : floor_idx_q + 2'd1;
            req_beyond = (next_idx == 2'd1) & req[2];
        end else if (state_q == MOVE_DOWN) begin
            next_idx   = (floor_idx_q == 2'd0) ? 2'd0 : floor_idx_q - 2'd1;
            req_beyond = (next_idx == 2'd1) & req[0];
        end
        req_next = req_at(req, next_idx);
    end

    always_comb begin
        state_d     = state_q;
        floor_idx_d = floor_idx_q;
        dir_up_d    = dir_up_q;
        timer_load  = 1'b0;
        timer_value = TRAVEL_LOAD;
        case (state_q)
            IDLE: begin
                if (req_here) begin
                    state_d     = DOOR;
                    timer_load  = 1'b1;
                    timer_value = DOOR_LOAD;
                end else if (dir_up_q && req_above) begin
                    state_d    = MOVE_UP;
                    timer_load = 1'b1;
                end else if (req_below) begin
                    state_d    = MOVE_DOWN;
                    dir_up_d   = 1'b0;
                    timer_load = 1'b1;
                end else if (req_above) begin
                    state_d    = MOVE_UP;
                    dir_up_d   = 1'b1;
                    timer_load = 1'b1;
                end
            end
            MOVE_UP, MOVE_DOWN: begin
                if (timer_expired) begin
                    floor_idx_d = next_idx;
                    if (req_next) begin
                        state_d     = DOOR;
                        timer_load  = 1'b1;
                        timer_value = DOOR_LOAD;
                    end else if (req_beyond) begin
                        timer_load = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                // A fresh press at this floor keeps the door open, even on the last cycle.
                if (req_here) begin
                    timer_load  = 1'b1;
                    timer_value = DOOR_LOAD;
                end else if (timer_expired) begin
                    state_d = IDLE;
                end
            end
        endcase
        move_d = (state_d == MOVE_UP) || (state_d == MOVE_DOWN);
        door_d = (state_d == DOOR);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            floor_idx_q <= 2'd0;
            dir_up_q    <= 1'b1;
            move_q      <= 1'b0;
            door_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            floor_idx_q <= floor_idx_d;
            dir_up_q    <= dir_up_d;
            move_q      <= move_d;
            door_q      <= door_d;
        end
    end

    always_comb begin
        case (floor_idx_q)
            2'd0:    floor = labelF1;
            2'd1:    floor = labelF2;
            default: floor = labelF3;
        endcase
    end

    assign move_handler = move_q;
    assign door_open    = door_q;
    assign dir_up       = dir_up_q;

endmodule

// File: tb/tb_elevator_controller.sv
// Bench for elevator_controller: emulates the button stage, runs directed
// scenarios and random traffic against a cycle-level behavioural model.
module tb_elevator_controller;

    localparam int T = 4;
    localparam int D = 6;

    logic       clk;
    logic       rst;
    logic [2:0] req;
    logic [1:0] floor;
    logic       move_handler;
    logic       dir_up;
    logic       door_open;

    int tests_run;
    int tests_failed;

    logic [2:0] lamps;
    string      m_mode;
    int         m_floor;
    bit         m_dir;
    int         m_left;

    elevator_controller #(
        .TRAVEL_CYCLES(T),
        .DOOR_CYCLES  (D)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .floor       (floor),
        .move_handler(move_handler),
        .dir_up      (dir_up),
        .door_open   (door_open)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [3:0] got, input logic [3:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit has_req(input logic [2:0] r, input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            if (i >= 0 && i <= 2 && r[i]) return 1'b1;
        end
        return 1'b0;
    endfunction

    // Model tracks how many cycles remain in the current travel leg or door opening.
    task automatic modelStep(input logic [2:0] r, input logic rs);
        int nf;
        if (rs) begin
            m_mode = "idle"; m_floor = 0; m_dir = 1'b1; m_left = 0;
        end else if (m_mode == "idle") begin
            if (r[m_floor]) begin
                m_mode = "door"; m_left = D;
            end else if (m_dir && has_req(r, m_floor + 1, 2)) begin
                m_mode = "up"; m_left = T;
            end else if (has_req(r, 0, m_floor - 1)) begin
                m_mode = "down"; m_dir = 1'b0; m_left = T;
            end else if (has_req(r, m_floor + 1, 2)) begin
                m_mode = "up"; m_dir = 1'b1; m_left = T;
            end
        end else if (m_mode == "up" || m_mode == "down") begin
            if (m_left > 1) begin
                m_left--;
            end else begin
                nf = (m_mode == "up") ? m_floor + 1 : m_floor - 1;
                m_floor = nf;
                if (r[nf]) begin
                    m_mode = "door"; m_left = D;
                end else if ((m_mode == "up") ? has_req(r, nf + 1, 2) : has_req(r, 0, nf - 1)) begin
                    m_left = T;
                end else begin
                    m_mode = "idle";
                end
            end
        end else begin
            if (r[m_floor]) m_left = D;
            else if (m_left > 1) m_left--;
            else m_mode = "idle";
        end
    endtask

    // One clock: button stage clears the lamp at the car, adds new presses, then compare.
    task automatic applyStimulus(input logic [2:0] press, input logic do_rst);
        lamps[m_floor] = 1'b0;
        lamps = lamps | press;
        req = lamps;
        rst = do_rst;
        @(posedge clk);
        modelStep(req, rst);
        #1;
        checkOutput("floor", {2'b00, floor}, {2'b00, 2'(m_floor)});
        checkOutput("move_handler", {3'b000, move_handler}, {3'b000, (m_mode == "up" || m_mode == "down")});
        checkOutput("door_open", {3'b000, door_open}, {3'b000, (m_mode == "door")});
        checkOutput("dir_up", {3'b000, dir_up}, {3'b000, m_dir});
    endtask

    initial begin
        int         door_cycles;
        int         door_floors[$];
        logic       prev_door;
        logic [2:0] press;

        tests_run = 0; tests_failed = 0;
        lamps = 3'b000; req = 3'b000; rst = 1'b1;
        m_mode = "idle"; m_floor = 0; m_dir = 1'b1; m_left = 0;
        #2;

        // Reset state and a quiet idle period.
        applyStimulus(3'b000, 1'b1);
        applyStimulus(3'b000, 1'b1);
        checkOutput("t1_floor", {2'b00, floor}, 4'h0);
        checkOutput("t1_dir_up", {3'b000, dir_up}, 4'h1);
        checkOutput("t1_move", {3'b000, move_handler}, 4'h0);
        checkOutput("t1_door", {3'b000, door_open}, 4'h0);
        for (int i = 0; i < 20; i++) applyStimulus(3'b000, 1'b0);
        checkOutput("t1_idle_hold", {2'b00, floor}, 4'h0);

        // F1 to F3 non-stop, then door, then idle.
        door_cycles = 0;
        applyStimulus(3'b100, 1'b0);
        checkOutput("t2_move_rise", {3'b000, move_handler}, 4'h1);
        for (int k = 2; k <= 2 * T + D + 1; k++) begin
            applyStimulus(3'b000, 1'b0);
            if (door_open) door_cycles++;
            if (k == T + 1) checkOutput("t2_pass_f2", {2'b00, floor}, 4'h1);
            if (k == T + 1) checkOutput("t2_no_stop_f2", {3'b000, move_handler}, 4'h1);
            if (k == 2 * T + 1) checkOutput("t2_arrive_f3", {2'b00, floor}, 4'h2);
            if (k == 2 * T + 1) checkOutput("t2_door_open", {3'b000, door_open}, 4'h1);
            if (k == 2 * T + D + 1) checkOutput("t2_door_closed", {3'b000, door_open}, 4'h0);
        end
        checkOutput("t2_door_len", 4'(door_cycles), 4'(D));

        // Mid-travel request for F2 causes a stop; F3 still served.
        applyStimulus(3'b000, 1'b1);
        applyStimulus(3'b100, 1'b0);
        applyStimulus(3'b000, 1'b0);
        applyStimulus(3'b010, 1'b0);
        door_floors.delete();
        prev_door = 1'b0;
        for (int i = 0; i < 40; i++) begin
            applyStimulus(3'b000, 1'b0);
            if (door_open && !prev_door) door_floors.push_back(int'(floor));
            prev_door = door_open;
        end
        checkOutput("t3_stops", 4'(door_floors.size()), 4'd2);
        if (door_floors.size() == 2) begin
            checkOutput("t3_first_stop", 4'(door_floors[0]), 4'd1);
            checkOutput("t3_second_stop", 4'(door_floors[1]), 4'd2);
        end

        // At F2 going up with calls both ways: up first, then down.
        applyStimulus(3'b000, 1'b1);
        applyStimulus(3'b010, 1'b0);
        for (int i = 0; i < 12; i++) applyStimulus(3'b000, 1'b0);
        checkOutput("t4_at_f2", {2'b00, floor}, 4'h1);
        applyStimulus(3'b101, 1'b0);
        door_floors.delete();
        prev_door = 1'b0;
        for (int i = 0; i < 50; i++) begin
            applyStimulus(3'b000, 1'b0);
            if (door_open && !prev_door) door_floors.push_back(int'(floor));
            prev_door = door_open;
        end
        checkOutput("t4_stops", 4'(door_floors.size()), 4'd2);
        if (door_floors.size() == 2) begin
            checkOutput("t4_first_up", 4'(door_floors[0]), 4'd2);
            checkOutput("t4_then_down", 4'(door_floors[1]), 4'd0);
        end

        // Door at F2 opens on the next edge and a re-press holds it D more cycles.
        applyStimulus(3'b000, 1'b1);
        applyStimulus(3'b010, 1'b0);
        for (int i = 0; i < 12; i++) applyStimulus(3'b000, 1'b0);
        applyStimulus(3'b010, 1'b0);
        checkOutput("t5_door_next_edge", {3'b000, door_open}, 4'h1);
        applyStimulus(3'b000, 1'b0);
        applyStimulus(3'b000, 1'b0);
        applyStimulus(3'b010, 1'b0);
        for (int j = 1; j <= D; j++) begin
            applyStimulus(3'b000, 1'b0);
            if (j == D - 1) checkOutput("t5_door_held", {3'b000, door_open}, 4'h1);
            if (j == D) checkOutput("t5_door_closed", {3'b000, door_open}, 4'h0);
        end

        // Reset mid-travel between F2 and F3.
        applyStimulus(3'b000, 1'b1);
        applyStimulus(3'b100, 1'b0);
        for (int i = 0; i < T + 2; i++) applyStimulus(3'b000, 1'b0);
        checkOutput("t6_moving_from_f2", {1'b0, move_handler, floor}, 4'h5);
        applyStimulus(3'b000, 1'b1);
        checkOutput("t6_floor", {2'b00, floor}, 4'h0);
        checkOutput("t6_move", {3'b000, move_handler}, 4'h0);
        checkOutput("t6_door", {3'b000, door_open}, 4'h0);
        checkOutput("t6_dir_up", {3'b000, dir_up}, 4'h1);

        // Random traffic with occasional resets.
        for (int i = 0; i < 1500; i++) begin
            press = 3'b000;
            for (int b = 0; b < 3; b++) press[b] = ($urandom_range(0, 15) == 0);
            applyStimulus(press, $urandom_range(0, 299) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
